moving_avg_decim: RTL

Boxcar (moving-average) accumulator and decimator that sits directly downstream of the `data_delay` line in the DDC filter chain. Every clock it adds the newest sample and subtracts the sample leaving the window, which the delay line supplies `delay_length` cycles later. It scales the running sum back to the input width and emits one averaged sample every `dec_factor` clocks. Output uses a valid/ready handshake and has a sticky overrun flag.

---
 rtl/moving_avg_decim.sv | 132 +++++++++++++
 1 files changed

// File: rtl/moving_avg_decim.sv
// rtl/moving_avg_decim.sv - boxcar moving-average accumulator and decimator with valid/ready output
//
// Purpose: running sum over a window of delay_length samples (newest sample added,
// the sample leaving the window subtracted), scaled back to bus_length bits and
// emitted once every dec_factor clocks through a valid/ready register stage.
//
// Ports:
//   clk_in        sample clock, one sample per clock
//   rst_n         asynchronous active-low reset
//   data_in       newest signed sample
//   data_delayed  data_in from delay_length clocks earlier (external delay line)
//   out_data      signed averaged sample
//   out_valid     out_data holds a result not yet accepted
//   out_ready     consumer accepts out_data when out_valid is also 1
//   overrun       sticky: a pending result was overwritten before acceptance
//   ovr_clr       synchronous clear for overrun (a simultaneous set wins)
//
// Build option: MAVG_ROUND_EN adds 2^(S-1) before the scaling shift (round half up);
// without it the shift floors toward -inf.
module moving_avg_decim #(
  parameter int bus_length   = 16,
  parameter int delay_length = 32,
  parameter int dec_factor   = 8
) (
  input  logic                         clk_in,
  input  logic                         rst_n,
  input  logic signed [bus_length-1:0] data_in,
  input  logic signed [bus_length-1:0] data_delayed,
  output logic signed [bus_length-1:0] out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         overrun,
  input  logic                         ovr_clr
);

  localparam int S  = $clog2(delay_length);
  localparam int AW = bus_length + S;
  localparam int WW = $clog2(delay_length + 1);
  localparam int DW = (dec_factor > 1) ? $clog2(dec_factor) : 1;

  localparam logic [WW-1:0] WCNT_FULL       = WW'(delay_length);
  localparam logic [WW-1:0] WCNT_LAST       = WW'(delay_length - 1);
  localparam logic [DW-1:0] DCNT_MAX        = DW'(dec_factor - 1);
  localparam logic [DW-1:0] DCNT_AFTER_FULL = (dec_factor > 1) ? DW'(1) : DW'(0);

  logic signed [AW-1:0]         r_acc;
  logic        [WW-1:0]         r_wcnt;
  logic        [DW-1:0]         r_dcnt;
  logic signed [bus_length-1:0] r_out_data;
  logic                         r_out_valid;
  logic                         r_overrun;

  logic signed [AW-1:0]         w_in_ext;
  logic signed [AW-1:0]         w_sub;
  logic signed [AW-1:0]         w_acc_next;
  logic                         w_win_full;
  logic                         w_steady;
  logic                         w_produce;
  logic signed [bus_length-1:0] w_avg;
  logic                         w_ovr_set;

  assign w_in_ext = AW'(data_in);

  // The delay line is not reset, so its output is ignored until a full
  // window of post-reset samples has entered it.
  assign w_steady   = (r_wcnt == WCNT_FULL);
  assign w_win_full = (r_wcnt == WCNT_LAST);
  assign w_sub      = w_steady ? AW'(data_delayed) : '0;
  assign w_acc_next = r_acc + w_in_ext - w_sub;

  assign w_produce  = w_win_full | (w_steady & (r_dcnt == '0));

`ifdef MAVG_ROUND_EN
  localparam int RND_INT = (S > 0) ? (1 << ((S > 0) ? (S - 1) : 0)) : 0;
  localparam logic signed [AW:0] RND = (AW + 1)'(RND_INT);

  // One guard bit above the accumulator so the rounding offset cannot wrap.
  logic signed [AW:0] w_rnd;
  logic               w_rnd_unused;
  assign w_rnd        = (AW + 1)'(w_acc_next) + RND;
  assign w_avg        = w_rnd[S +: bus_length];
  assign w_rnd_unused = ^w_rnd;
`else
  // Taking bits [S +: bus_length] is the arithmetic right shift by S,
  // truncated to the output width.
  assign w_avg = w_acc_next[S +: bus_length];
`endif

  assign w_ovr_set = w_produce & r_out_valid & ~out_ready;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_acc       <= '0;
      r_wcnt      <= '0;
      r_dcnt      <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_acc <= w_acc_next;

      if (!w_steady) begin
        r_wcnt <= r_wcnt + WW'(1);
      end

      // Phase is anchored to the window-full clock, which itself produces.
      if (w_win_full) begin
        r_dcnt <= DCNT_AFTER_FULL;
      end else if (w_steady) begin
        r_dcnt <= (r_dcnt == DCNT_MAX) ? '0 : r_dcnt + DW'(1);
      end

      if (w_produce) begin
        r_out_data  <= w_avg;
        r_out_valid <= 1'b1;
      end else if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end

      if (w_ovr_set) begin
        r_overrun <= 1'b1;
      end else if (ovr_clr) begin
        r_overrun <= 1'b0;
      end
    end
  end

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign overrun   = r_overrun;

endmodule
